wb_port_arbiter: RTL and testbench

Registered arbiter sharing the single register-file write port between the in-order pipeline write-back and out-of-order late producers (multi-cycle mul/div, late load return). It sits after the write-back stage and drives the register file write signals. The pipeline gets fixed priority. The other requesters are served round-robin, and a starvation counter forces a pipeline stall so no late producer waits indefinitely.

---
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter_if : requester handshakes and register-file write port. rev 1.0
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int size    = 32
);
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*5-1:0]    req_rd_i;
    logic [NUM_REQ*size-1:0] req_data_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    stall_o;
    logic [4:0]              RD_WB;
    logic                    WE_WB;
    logic [size-1:0]         Final_Result;
    logic [2:0]              grant_id_o;

    modport master (
        output req_valid_i, req_rd_i, req_data_i,
        input  req_ready_o, stall_o, RD_WB, WE_WB, Final_Result, grant_id_o
    );

    modport slave (
        input  req_valid_i, req_rd_i, req_data_i,
        output req_ready_o, stall_o, RD_WB, WE_WB, Final_Result, grant_id_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter : register-file write-port arbiter, pipeline first, late RR. rev 1.0
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int size         = 32,
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 4
) (
    input wire               clk,
    input wire               reset,
    wb_port_arbiter_if.slave bus
);
    localparam logic [2:0] c_rr_reset     = 3'(NUM_REQ - 1);
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_STARVE = 1'b1
    } arb_mode_t;

    arb_mode_t       mode_q, mode_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            we_wb_q, we_wb_d;
    logic [4:0]      rd_wb_q, rd_wb_d;
    logic [size-1:0] result_q, result_d;
    logic [2:0]      grant_id_q, grant_id_d;

    logic               w_hi_found, w_lo_found, w_late_any;
    logic [2:0]         w_hi_idx, w_lo_idx, w_rr_idx;
    logic               w_grant_any, w_late_grant;
    logic [2:0]         w_grant_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [4:0]         w_sel_rd;
    logic [size-1:0]    w_sel_data;

    // Round-robin: lowest valid index above rr_ptr wins, else lowest at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 1; k--) begin
            if (bus.req_valid_i[k]) begin
                if (3'(k) > rr_ptr_q) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(k);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = 3'(k);
                end
            end
        end
        w_late_any = w_hi_found | w_lo_found;
        w_rr_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (reset) begin
            if (mode_q == ARB_NORMAL && bus.req_valid_i[0]) begin
                w_grant_any = 1'b1;
                w_grant_idx = 3'd0;
            end else if (w_late_any) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_rr_idx;
            end
        end
        w_late_grant = w_grant_any && (w_grant_idx != 3'd0);

        w_ready    = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_any && w_grant_idx == 3'(k)) begin
                w_ready[k] = 1'b1;
                w_sel_rd   = bus.req_rd_i[5*k +: 5];
                w_sel_data = bus.req_data_i[size*k +: size];
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        we_wb_d    = 1'b0;
        rd_wb_d    = rd_wb_q;
        result_d   = result_q;
        grant_id_d = grant_id_q;

        if (w_grant_any) begin
            we_wb_d    = (w_sel_rd != 5'd0);
            rd_wb_d    = w_sel_rd;
            result_d   = w_sel_data;
            grant_id_d = w_grant_idx;
        end

        if (w_late_grant) begin
            rr_ptr_d = w_grant_idx;
        end

        case (mode_q)
            // A starve slot lasts one cycle: it either serves a late requester or finds none left.
            ARB_STARVE: begin
                mode_d     = ARB_NORMAL;
                wait_cnt_d = '0;
            end
            ARB_NORMAL: begin
                if (w_late_grant) begin
                    wait_cnt_d = '0;
                end else if (w_late_any) begin
                    if (wait_cnt_q >= c_starve_limit) begin
                        mode_d = ARB_STARVE;
                    end
                    if (wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= ARB_NORMAL;
            rr_ptr_q   <= c_rr_reset;
            wait_cnt_q <= '0;
            we_wb_q    <= 1'b0;
            rd_wb_q    <= '0;
            result_q   <= '0;
            grant_id_q <= '0;
        end else begin
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            we_wb_q    <= we_wb_d;
            rd_wb_q    <= rd_wb_d;
            result_q   <= result_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.req_ready_o  = w_ready;
    assign bus.stall_o      = reset && (mode_q == ARB_STARVE);
    assign bus.WE_WB        = we_wb_q;
    assign bus.RD_WB        = rd_wb_q;
    assign bus.Final_Result = result_q;
    assign bus.grant_id_o   = grant_id_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter : vector table, corner sequences and random run vs model. rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
    localparam int NR    = 3;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    localparam logic [31:0] D0 = 32'hC0DE_0000;
    localparam logic [31:0] D1 = 32'h1111_0001;
    localparam logic [31:0] D2 = 32'h2222_0002;

    typedef struct packed {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_stall;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_res;
        logic [2:0]  exp_gid;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_last;
    int          m_wait;
    bit          m_starve;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    int          m_gid;

    vec_t tbl [14];

    wb_port_arbiter_if #(.NUM_REQ(NR), .size(DW)) bus ();

    wb_port_arbiter #(.size(DW), .NUM_REQ(NR), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: next late requester after the last one served, wrapping over 1..NR-1.
    function automatic int late_pick();
        for (int s = 1; s < NR; s++) begin
            int k;
            k = ((m_last - 1 + s) % (NR - 1)) + 1;
            if (bus.req_valid_i[k]) return k;
        end
        return -1;
    endfunction

    function automatic int model_pick();
        if (!reset) return -1;
        if (m_starve) return late_pick();
        if (bus.req_valid_i[0]) return 0;
        return late_pick();
    endfunction

    function automatic logic [2:0] ready_of(input int g);
        logic [2:0] r;
        r = 3'b000;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_update(input int g);
        bit late_waiting;
        if (!reset) begin
            m_last = NR - 1; m_wait = 0; m_starve = 0;
            m_we = 0; m_rd = 0; m_res = 0; m_gid = 0;
            return;
        end
        late_waiting = (late_pick() >= 0);
        if (g >= 0) begin
            m_rd  = bus.req_rd_i[5*g +: 5];
            m_res = bus.req_data_i[32*g +: 32];
            m_we  = (m_rd != 0);
            m_gid = g;
        end else begin
            m_we = 0;
        end
        if (m_starve) begin
            m_starve = 0;
            m_wait   = 0;
        end else if (g >= 1) begin
            m_wait = 0;
        end else if (late_waiting) begin
            m_starve = (m_wait >= LIMIT);
            m_wait   = (m_wait < 15) ? m_wait + 1 : 15;
        end
        if (g >= 1) m_last = g;
    endfunction

    task automatic pre_edge(output int g);
        #2;
        g = model_pick();
    endtask

    task automatic post_edge(input int g);
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic hand_cycle(input string tag, input logic [2:0] v, input logic [2:0] xr, input logic xs);
        int g;
        bus.req_valid_i = v;
        pre_edge(g);
        chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'(xr));
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'(xs));
        post_edge(g);
    endtask

    task automatic do_reset();
        int g;
        reset = 1'b0;
        bus.req_valid_i = '0;
        pre_edge(g);
        post_edge(g);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                                input logic [2:0] r, input logic s, input logic we,
                                input logic [4:0] xrd, input logic [31:0] xres, input logic [2:0] gid);
        vec_t t;
        t = '{v, rd, d, r, s, we, xrd, xres, gid};
        return t;
    endfunction

    initial begin
        int g;
        tbl[0]  = mk(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0);
        tbl[1]  = mk(3'b110, {5'd2, 5'd1, 5'd0}, {D2, D1, 32'h0}, 3'b010, 1'b0, 1'b1, 5'd1, D1, 3'd1);
        tbl[2]  = mk(3'b110, {5'd2, 5'd1, 5'd0}, {D2, D1, 32'h0}, 3'b100, 1'b0, 1'b1, 5'd2, D2, 3'd2);
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[2];
        tbl[5]  = mk(3'b100, {5'd0, 5'd1, 5'd0}, {32'h1234, D1, 32'h0}, 3'b100, 1'b0, 1'b0, 5'd0, 32'h1234, 3'd2);
        tbl[6]  = mk(3'b000, {5'd0, 5'd1, 5'd0}, {32'h1234, D1, 32'h0}, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234, 3'd2);
        for (int i = 7; i < 12; i++)
            tbl[i] = mk(3'b011, {5'd0, 5'd7, 5'd3}, {32'h0, D1, D0}, 3'b001, 1'b0, 1'b1, 5'd3, D0, 3'd0);
        tbl[12] = mk(3'b011, {5'd0, 5'd7, 5'd3}, {32'h0, D1, D0}, 3'b010, 1'b1, 1'b1, 5'd7, D1, 3'd1);
        tbl[13] = tbl[7];

        // Reset cycle with every requester valid: nothing may be granted or written.
        bus.req_valid_i = 3'b111;
        bus.req_rd_i    = {5'd9, 5'd8, 5'd7};
        bus.req_data_i  = {D2, D1, D0};
        reset = 1'b0;
        pre_edge(g);
        chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_stall", 32'(bus.stall_o), 32'h0);
        post_edge(g);
        chk("rst_we",  32'(bus.WE_WB), 32'h0);
        chk("rst_rd",  32'(bus.RD_WB), 32'h0);
        chk("rst_res", bus.Final_Result, 32'h0);
        chk("rst_gid", 32'(bus.grant_id_o), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus.req_valid_i = tbl[i].valid;
            bus.req_rd_i    = tbl[i].rd;
            bus.req_data_i  = tbl[i].data;
            pre_edge(g);
            chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready_o), 32'(tbl[i].exp_ready));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(tbl[i].exp_stall));
            post_edge(g);
            chk($sformatf("vec%0d_we", i),  32'(bus.WE_WB), 32'(tbl[i].exp_we));
            chk($sformatf("vec%0d_rd", i),  32'(bus.RD_WB), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_res", i), bus.Final_Result, tbl[i].exp_res);
            chk($sformatf("vec%0d_gid", i), 32'(bus.grant_id_o), 32'(tbl[i].exp_gid));
        end

        // Late requester withdraws during its starve slot.
        do_reset();
        bus.req_rd_i   = {5'd0, 5'd7, 5'd3};
        bus.req_data_i = {32'h0, D1, D0};
        for (int c = 0; c < 5; c++) hand_cycle("drop_wait", 3'b011, 3'b001, 1'b0);
        hand_cycle("drop_starve", 3'b001, 3'b000, 1'b1);
        hand_cycle("drop_after", 3'b001, 3'b001, 1'b0);
        chk("drop_after_we",  32'(bus.WE_WB), 32'h1);
        chk("drop_after_gid", 32'(bus.grant_id_o), 32'h0);

        // Reset while requester 1 is waiting: wait count restarts from zero.
        do_reset();
        hand_cycle("mid_wait", 3'b011, 3'b001, 1'b0);
        hand_cycle("mid_wait", 3'b011, 3'b001, 1'b0);
        reset = 1'b0;
        hand_cycle("mid_rst", 3'b011, 3'b000, 1'b0);
        chk("mid_rst_we", 32'(bus.WE_WB), 32'h0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) hand_cycle("mid_rel", 3'b011, 3'b001, 1'b0);
        hand_cycle("mid_starve", 3'b011, 3'b010, 1'b1);
        chk("mid_starve_we",  32'(bus.WE_WB), 32'h1);
        chk("mid_starve_gid", 32'(bus.grant_id_o), 32'h1);
        chk("mid_starve_rd",  32'(bus.RD_WB), 32'd7);

        // Random traffic with held requests, occasional withdrawals and resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (!bus.req_valid_i[k] && $urandom_range(0, 99) < ((k == 0) ? 45 : 30)) begin
                    bus.req_valid_i[k]         = 1'b1;
                    bus.req_rd_i[5*k +: 5]     = 5'($urandom_range(0, 31));
                    bus.req_data_i[32*k +: 32] = $urandom;
                end
            end
            reset = ($urandom_range(0, 299) != 0);
            pre_edge(g);
            chk("rand_ready", 32'(bus.req_ready_o), 32'(ready_of(g)));
            chk("rand_stall", 32'(bus.stall_o), 32'(reset && m_starve));
            post_edge(g);
            chk("rand_we",  32'(bus.WE_WB), 32'(m_we));
            chk("rand_rd",  32'(bus.RD_WB), 32'(m_rd));
            chk("rand_res", bus.Final_Result, m_res);
            chk("rand_gid", 32'(bus.grant_id_o), 32'(m_gid));
            if (g >= 0) bus.req_valid_i[g] = 1'b0;
            for (int k = 1; k < NR; k++)
                if (bus.req_valid_i[k] && $urandom_range(0, 99) < 3) bus.req_valid_i[k] = 1'b0;
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
